// File: rtl/avm_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM arbiter.
package avm_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMD   = 2'd1,
    S_RDATA = 2'd2
  } state_e;

  localparam int AW_DEF  = 32;
  localparam int DW_DEF  = 16;
  localparam int BEW_DEF = 2;

  // Read data returned on a watchdog completion; sliced to the data width at use.
  localparam logic [63:0] TIMEOUT_FILL = '1;

endpackage

// File: rtl/avm_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt
);

  always_comb begin
    gnt = ~last;
    if (req == 2'b01) begin
      gnt = 1'b0;
    end else if (req == 2'b10) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/avm_arbiter.sv
// Shares one Avalon-MM master port between two requesters: round-robin grant,
// one transaction in flight, and a read-data watchdog.
module avm_arbiter
  import avm_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int BEW      = BEW_DEF,
  parameter int TIMEOUT  = 255,
  parameter bit M0_FIRST = 1'b1
) (
  input  logic           avm_clk,
  input  logic           avm_reset,
  input  logic [AW-1:0]  m0_addr,
  input  logic           m0_rd,
  input  logic           m0_wr,
  input  logic [DW-1:0]  m0_wdata,
  input  logic [BEW-1:0] m0_byte_en,
  output logic           m0_wait,
  output logic           m0_rdvalid,
  output logic [DW-1:0]  m0_rdata,
  input  logic [AW-1:0]  m1_addr,
  input  logic           m1_rd,
  input  logic           m1_wr,
  input  logic [DW-1:0]  m1_wdata,
  input  logic [BEW-1:0] m1_byte_en,
  output logic           m1_wait,
  output logic           m1_rdvalid,
  output logic [DW-1:0]  m1_rdata,
  output logic [AW-1:0]  avm_addr,
  output logic           avm_rd,
  output logic           avm_wr,
  output logic [DW-1:0]  avm_wdata,
  output logic [BEW-1:0] avm_byte_en,
  input  logic           avm_wait,
  input  logic           avm_rdvalid,
  input  logic [DW-1:0]  avm_rdata,
  output logic           err_timeout
);

  localparam int TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;

  logic [1:0] req;
  logic       pick;
  logic       g_rd, g_wr, g_req;
  logic       cmd_act, rdata_act, accept, rd_acc, wd_fire, rdv_any;

  assign req = {m1_rd | m1_wr, m0_rd | m0_wr};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // last_q names the requester that loses the next tie, so resetting it to
  // M0_FIRST hands the first contested grant to m0 when M0_FIRST is set.
  always_ff @(posedge avm_clk) begin
    if (avm_reset) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      last_q  <= M0_FIRST;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    g_rd      = grant_q ? m1_rd : m0_rd;
    g_wr      = grant_q ? m1_wr : m0_wr;
    g_req     = g_rd | g_wr;
    // Reset masks everything so an aborted transaction issues and returns nothing.
    cmd_act   = (state_q == S_CMD) & ~avm_reset;
    rdata_act = (state_q == S_RDATA) & ~avm_reset;
    accept    = cmd_act & g_req & ~avm_wait;
    rd_acc    = accept & g_rd;
    wd_fire   = rdata_act & (TIMEOUT != 0) & ~avm_rdvalid &
                (tcnt_q == TCW'(TIMEOUT - 1));
    rdv_any   = (avm_rdvalid & (rdata_act | rd_acc)) | wd_fire;
  end

  assign avm_addr    = grant_q ? m1_addr    : m0_addr;
  assign avm_wdata   = grant_q ? m1_wdata   : m0_wdata;
  assign avm_byte_en = grant_q ? m1_byte_en : m0_byte_en;
  assign avm_rd      = cmd_act & g_rd;
  assign avm_wr      = cmd_act & g_wr & ~g_rd;

  assign m0_wait     = req[0] & ~(cmd_act & ~grant_q & ~avm_wait);
  assign m1_wait     = req[1] & ~(cmd_act &  grant_q & ~avm_wait);
  assign m0_rdvalid  = rdv_any & ~grant_q;
  assign m1_rdvalid  = rdv_any &  grant_q;
  assign m0_rdata    = wd_fire ? TIMEOUT_FILL[DW-1:0] : avm_rdata;
  assign m1_rdata    = m0_rdata;
  assign err_timeout = wd_fire;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d = pick;
          last_d  = pick;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (!g_req) begin
          state_d = S_IDLE;
        end else if (!avm_wait) begin
          tcnt_d  = '0;
          state_d = (g_rd && !avm_rdvalid) ? S_RDATA : S_IDLE;
        end
      end
      S_RDATA: begin
        tcnt_d = tcnt_q + TCW'(1);
        if (avm_rdvalid || wd_fire) begin
          tcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_avm_arbiter.sv
// Directed bench for avm_arbiter: reset, writes, round-robin contention, read latency,
// watchdog completion and reset during an outstanding read.
module tb_avm_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr, avm_addr;
  logic        m0_rd, m0_wr, m1_rd, m1_wr;
  logic [15:0] m0_wdata, m1_wdata, avm_wdata;
  logic [1:0]  m0_be, m1_be, avm_be;
  logic        m0_wait, m1_wait, m0_rdvalid, m1_rdvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        avm_rd, avm_wr, avm_wait, avm_rdvalid, err_timeout;
  logic [15:0] avm_rdata;

  int checks = 0;
  int errors = 0;
  int expg;

  always #5 clk = ~clk;

  avm_arbiter #(.AW(32), .DW(16), .BEW(2), .TIMEOUT(8), .M0_FIRST(1'b1)) dut (
    .avm_clk(clk), .avm_reset(rst),
    .m0_addr(m0_addr), .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_wdata(m0_wdata),
    .m0_byte_en(m0_be), .m0_wait(m0_wait), .m0_rdvalid(m0_rdvalid), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_wdata(m1_wdata),
    .m1_byte_en(m1_be), .m1_wait(m1_wait), .m1_rdvalid(m1_rdvalid), .m1_rdata(m1_rdata),
    .avm_addr(avm_addr), .avm_rd(avm_rd), .avm_wr(avm_wr), .avm_wdata(avm_wdata),
    .avm_byte_en(avm_be), .avm_wait(avm_wait), .avm_rdvalid(avm_rdvalid),
    .avm_rdata(avm_rdata), .err_timeout(err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_addr = 32'h40; m0_rd = 1'b1; m0_wr = 1'b0; m0_wdata = 16'h0; m0_be = 2'b11;
    m1_addr = 32'h0;  m1_rd = 1'b0; m1_wr = 1'b0; m1_wdata = 16'h0; m1_be = 2'b00;
    avm_wait = 1'b0; avm_rdvalid = 1'b0; avm_rdata = 16'h0;

    // 1: reset held two cycles with m0_rd pending
    tick();
    chk("rst_avm_rd", avm_rd, 0);
    chk("rst_m0_wait", m0_wait, 1);
    tick();
    chk("rst_avm_rd2", avm_rd, 0);
    rst = 1'b0;
    #1;
    chk("arb_avm_rd", avm_rd, 0);
    chk("arb_m0_wait", m0_wait, 1);
    tick();
    avm_rdvalid = 1'b1; avm_rdata = 16'h0BEE;
    #1;
    chk("g0_avm_rd", avm_rd, 1);
    chk("g0_addr", avm_addr, 32'h40);
    chk("g0_m0_wait", m0_wait, 0);
    chk("g0_m0_rdvalid", m0_rdvalid, 1);
    chk("g0_m0_rdata", m0_rdata, 16'h0BEE);
    tick();
    m0_rd = 1'b0; avm_rdvalid = 1'b0;

    // 2: single write from m1
    m1_addr = 32'h0020_0010; m1_wdata = 16'hA55A; m1_be = 2'b11; m1_wr = 1'b1;
    #1;
    chk("w_idle_avm_wr", avm_wr, 0);
    chk("w_idle_m1_wait", m1_wait, 1);
    tick();
    chk("w_avm_wr", avm_wr, 1);
    chk("w_addr", avm_addr, 32'h0020_0010);
    chk("w_wdata", avm_wdata, 16'hA55A);
    chk("w_be", avm_be, 2'b11);
    chk("w_m1_wait", m1_wait, 0);
    chk("w_avm_rd", avm_rd, 0);
    tick();
    m1_wr = 1'b0;
    #1;
    chk("w_after_avm_wr", avm_wr, 0);

    // 3: contention, both requesters always pending at arbitration -> 0,1,0,1
    m0_rd = 1'b1; m1_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h300 + i; m1_addr = 32'h500 + i;
      #1;
      chk("c_idle_m0_wait", m0_wait, 1);
      chk("c_idle_m1_wait", m1_wait, 1);
      tick();
      expg = i % 2;
      avm_rdvalid = (expg == 0); avm_rdata = 16'h1000 + 16'(i);
      #1;
      chk("c_avm_rd", avm_rd, (expg == 0));
      chk("c_avm_wr", avm_wr, (expg == 1));
      chk("c_addr", avm_addr, (expg == 0) ? 32'h300 + i : 32'h500 + i);
      chk("c_m0_wait", m0_wait, (expg != 0));
      chk("c_m1_wait", m1_wait, (expg != 1));
      chk("c_m0_rdvalid", m0_rdvalid, (expg == 0));
      tick();
      avm_rdvalid = 1'b0;
    end
    m0_rd = 1'b0; m1_wr = 1'b0;

    // 4: read with 3 wait cycles, data 2 cycles after accept
    m0_addr = 32'h100; m0_rd = 1'b1; avm_wait = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rl_stall_avm_rd", avm_rd, 1);
      chk("rl_stall_m0_wait", m0_wait, 1);
      tick();
    end
    avm_wait = 1'b0;
    #1;
    chk("rl_acc_m0_wait", m0_wait, 0);
    chk("rl_acc_rdvalid", m0_rdvalid, 0);
    tick();
    m0_rd = 1'b0;
    #1;
    chk("rl_wait1_avm_rd", avm_rd, 0);
    chk("rl_wait1_rdvalid", m0_rdvalid, 0);
    tick();
    avm_rdvalid = 1'b1; avm_rdata = 16'h1234;
    #1;
    chk("rl_m0_rdvalid", m0_rdvalid, 1);
    chk("rl_m0_rdata", m0_rdata, 16'h1234);
    chk("rl_m1_rdvalid", m1_rdvalid, 0);
    tick();
    avm_rdvalid = 1'b0;
    #1;
    chk("rl_after_rdvalid", m0_rdvalid, 0);

    // 5: watchdog with TIMEOUT=8
    m0_addr = 32'h200; m0_rd = 1'b1; avm_rdata = 16'h5555;
    tick();
    #1;
    chk("to_acc_avm_rd", avm_rd, 1);
    tick();
    m0_rd = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("to_pending_err", err_timeout, 0);
      chk("to_pending_rdvalid", m0_rdvalid, 0);
      tick();
    end
    #1;
    chk("to_err", err_timeout, 1);
    chk("to_m0_rdvalid", m0_rdvalid, 1);
    chk("to_m0_rdata", m0_rdata, 16'hFFFF);
    chk("to_m1_rdvalid", m1_rdvalid, 0);
    tick();
    avm_rdvalid = 1'b1;
    #1;
    chk("to_err_clear", err_timeout, 0);
    chk("to_stray_m0", m0_rdvalid, 0);
    chk("to_stray_m1", m1_rdvalid, 0);
    tick();
    avm_rdvalid = 1'b0;

    // 6: reset while m1's read is outstanding
    m1_addr = 32'h700; m1_rd = 1'b1;
    tick();
    #1;
    chk("ra_acc_avm_rd", avm_rd, 1);
    tick();
    m1_rd = 1'b0;
    #1;
    chk("ra_rdata_m1_rdvalid", m1_rdvalid, 0);
    rst = 1'b1; avm_rdvalid = 1'b1; avm_rdata = 16'hCAFE;
    #1;
    chk("ra_rst_m1_rdvalid", m1_rdvalid, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("ra_idle_m1_rdvalid", m1_rdvalid, 0);
    chk("ra_idle_avm_rd", avm_rd, 0);
    tick();
    avm_rdvalid = 1'b0;
    m0_addr = 32'h900; m0_wdata = 16'h0F0F; m0_wr = 1'b1;
    tick();
    #1;
    chk("ra_next_avm_wr", avm_wr, 1);
    chk("ra_next_addr", avm_addr, 32'h900);
    tick();
    m0_wr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
